// File: rtl/button_press_decoder_pkg.sv
// Shared alarm-clock definitions: button FSM state encodings and the nominal tick rate.
package alarm_clock_defs;

  typedef enum logic [1:0] {
    BTN_ST_IDLE    = 2'd0,
    BTN_ST_PRESSED = 2'd1,
    BTN_ST_HELD    = 2'd2
  } btn_state_t;

  localparam int unsigned DEFAULT_TICK_HZ = 200;

endpackage

// File: rtl/button_press_decoder.sv
// Turns a debounced button level into press/release/long-press/auto-repeat pulses.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined; release is a reserved word, hence release_pulse.
module button_press_decoder
  import alarm_clock_defs::*;
#(
  parameter int unsigned HOLD_TICKS   = 200,
  parameter int unsigned REPEAT_TICKS = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_in,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic rpt,
  output logic held
);

  localparam int unsigned CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_TICKS - 1);
`endif

  btn_state_t       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= BTN_ST_IDLE;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      rpt           <= 1'b0;
      held          <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      rpt           <= 1'b0;
      case (state)
        BTN_ST_IDLE: begin
          if (btn_in) begin
            press <= 1'b1;
            cnt   <= '0;
            held  <= 1'b1;
            state <= BTN_ST_PRESSED;
          end
        end
        // Release is tested first so it beats a coincident threshold tick.
        BTN_ST_PRESSED: begin
          if (!btn_in) begin
            release_pulse <= 1'b1;
            cnt           <= '0;
            held          <= 1'b0;
            state         <= BTN_ST_IDLE;
          end else if (tick) begin
            if (cnt == HOLD_LAST) begin
              long_press <= 1'b1;
              cnt        <= '0;
              state      <= BTN_ST_HELD;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        BTN_ST_HELD: begin
          if (!btn_in) begin
            release_pulse <= 1'b1;
            cnt           <= '0;
            held          <= 1'b0;
            state         <= BTN_ST_IDLE;
          end else begin
`ifdef BTN_AUTOREPEAT_EN
            if (tick) begin
              if (cnt == RPT_LAST) begin
                rpt <= 1'b1;
                cnt <= '0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
`endif
          end
        end
        default: begin
          cnt   <= '0;
          held  <= 1'b0;
          state <= BTN_ST_IDLE;
        end
      endcase
    end
  end

endmodule
